link_sio_ctrl: RTL and testbench
================================

Name: link_sio_ctrl

Overview:
- Game Boy serial-port transfer controller: owns the SB (0xFF01) and SC (0xFF02) registers on the CPU memory bus.
- Sequences 8-bit MSB-first shift transfers, either on its own 8192 Hz internal clock or on an external link clock.
- Raises the serial interrupt at the end of each transfer.
- Presents each completed byte to downstream consumers, such as the UART bridge, via a one-cycle strobe.

Parameters:
- SB_ADDR, 16'hff01, address of the serial data register.
- SC_ADDR, 16'hff02, address of the serial control register.
- HALF_DIV, 256, clockgb cycles per internal serial clock half-period (4.194304 MHz / 8192 / 2). Legal range 2..511.

Ports:
- clockgb, input, 1, system clock (only clock).
- resetn, input, 1, asynchronous active-low reset.
- address, input, 16, CPU bus address.
- indata, input, 8, CPU write data.
- outdata, output, 8, CPU read data; 0 when neither register is addressed (OR-combined bus).
- load, input, 1, CPU read strobe.
- store, input, 1, CPU write strobe (one cycle per write).
- sin, input, 1, serial data in (asynchronous).
- sout, output, 1, serial data out.
- sclk_in, input, 1, external serial clock (asynchronous).
- sclk_out, output, 1, internal serial clock output.
- sclk_oe, output, 1, 1 while driving sclk_out (internal-clock transfer active).
- irq, output, 1, serial interrupt request, one-cycle pulse.
- byte_done, output, 1, one-cycle strobe: transfer completed.
- byte_data, output, 8, received byte, valid when byte_done=1; holds its value until the next completion.

Behaviour:
- Clock and reset: single clock clockgb. Reset is asynchronous, active-low resetn.
- Reset values:
  - sb=0, start=0, clksel=0, state=IDLE, bitcnt=0, divcnt=0.
  - sout=1, sclk_out=1, sclk_oe=0, irq=0, byte_done=0, byte_data=0.
  - Both synchroniser chains reset to 1.
- Reset asserted mid-transfer aborts immediately to these values. No irq is generated.
- Reads (combinational):
  - load && address==SB_ADDR → outdata=sb.
  - load && address==SC_ADDR → outdata={start,6'b111111,clksel}.
  - Otherwise outdata=0.
- Writes (take effect on the clock edge when store=1):
  - SB: sb<=indata in IDLE only. Ignored while a transfer is active.
  - SC in IDLE:
    - clksel<=indata[0].
    - If indata[7]=1: start<=1 and a transfer begins (see below).
  - SC while active:
    - indata[7]=0: abort. Go to IDLE, start=0, sclk_out=1, sclk_oe=0, sb keeps its partially shifted value, no irq, no byte_done.
    - indata[7]=1: ignored entirely, including clksel.
- Synchronisers: sin and sclk_in each pass through 2 flops. Edge detect on the synchronised sclk_in against its previous value.
- States: IDLE, LOW, HIGH.
  - Internal start (clksel=1):
    - Next cycle: state=LOW, sclk_oe=1, sclk_out=0, sout=sb[7], divcnt=0.
  - LOW (internal):
    - divcnt counts 0..HALF_DIV-1.
    - At terminal count: sclk_out=1, sb<={sb[6:0],sin_sync}, bitcnt++, state=HIGH, divcnt=0.
  - HIGH (internal):
    - At terminal count, if bitcnt==8 → COMPLETE.
    - Otherwise: sclk_out=0, sout=sb[7], state=LOW.
  - External (clksel=0):
    - sclk_oe=0, sclk_out=1 throughout. divcnt is unused.
    - Falling edge of synchronised sclk_in: sout=sb[7].
    - Rising edge: shift in sin_sync and bitcnt++.
    - Complete on the 8th rising edge (same cycle as the shift).
    - No timeout. Edges are ignored in IDLE.
  - COMPLETE (one cycle, then IDLE):
    - start=0, sclk_oe=0, sclk_out=1, sout=1, bitcnt=0.
    - irq=1 and byte_done=1 for exactly one cycle; byte_data<=final sb.
- Per-transfer timing: one internal-clock byte takes 16*HALF_DIV cycles from start to the completion pulse, ±1 cycle for the start-up cycle.
- Simultaneous events:
  - SC abort-write on the completing cycle wins: no irq, no byte_done.
  - SC start-write on the completing cycle is ignored.
  - An SB write on the completing cycle is ignored.
- bitcnt is 4 bits; divcnt is 9 bits. Neither counter wraps within a transfer.

Test Plan:
- Reset, then read FF01 → 0x00 and FF02 → 0x7E. Read any other address → 0x00.
- HALF_DIV=4, SB=0xA5, sin tied 1, write SC=0x81:
  - sout follows 1,0,1,0,0,1,0,1 on each sclk_out falling edge.
  - sclk_out period is 8 cycles.
  - After 64±1 cycles: irq and byte_done pulse for 1 cycle, byte_data=0xFF, FF01 reads 0xFF, FF02 reads 0x7F.
- External mode: SB=0x3C, write SC=0x80, drive 8 sclk_in pulses with sin pattern 0x5A:
  - sout shifts out 0x3C MSB-first.
  - irq is issued 2-3 cycles after the 8th rising edge; byte_data=0x5A.
  - With only 7 pulses: no irq and start stays 1.
- Mid-transfer abort: after 3 internal bits, write SC=0x01:
  - No irq, sclk_oe=0, FF02 reads 0x7F.
  - A subsequent SB write takes effect.
- During an active transfer, write SB=0x00 and SC=0x80:
  - Both are ignored; the transfer completes with the original data and clksel unchanged.
- Assert resetn low mid-transfer:
  - All outputs return to reset values asynchronously.
  - No irq after release.

Source files
------------

// File: rtl/link_sio_ctrl.sv
// Serial-port transfer controller that owns the SB and SC registers.
// Runs 8-bit MSB-first shifts on an internal divided clock or on an external link clock.
module link_sio_ctrl #(
  parameter logic [15:0] SB_ADDR  = 16'hff01,
  parameter logic [15:0] SC_ADDR  = 16'hff02,
  parameter int          HALF_DIV = 256
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  input  logic        sin,
  output logic        sout,
  input  logic        sclk_in,
  output logic        sclk_out,
  output logic        sclk_oe,
  output logic        irq,
  output logic        byte_done,
  output logic [7:0]  byte_data
);

  // state | meaning
  // IDLE  | no transfer; SB and SC writable
  // LOW   | internal: sclk_out low half-period; external: transfer in progress
  // HIGH  | internal: sclk_out high half-period (bit already sampled)
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [8:0] DIV_TC = 9'(HALF_DIV - 1);

  state_t      state;
  logic [7:0]  sb;
  logic        start;
  logic        clksel;
  logic [3:0]  bitcnt;
  logic [8:0]  divcnt;
  logic        sin_s1, sin_s2;
  logic        sck_s1, sck_s2, sck_prev;

  logic        wr_sb, wr_sc, active, div_tc, sck_rise, sck_fall;
  logic        abort, int_done, ext_done;
  logic [7:0]  sb_shift;

  assign wr_sb    = store && (address == SB_ADDR);
  assign wr_sc    = store && (address == SC_ADDR);
  assign active   = (state != IDLE);
  assign div_tc   = (divcnt == DIV_TC);
  assign sck_rise = sck_s2 && !sck_prev;
  assign sck_fall = !sck_s2 && sck_prev;
  assign sb_shift = {sb[6:0], sin_s2};

  // Abort takes priority over a completion landing in the same cycle.
  assign abort    = active && wr_sc && !indata[7];
  assign int_done = clksel && (state == HIGH) && div_tc && (bitcnt == 4'd8);
  assign ext_done = !clksel && (state == LOW) && sck_rise && (bitcnt == 4'd7);

  always_comb begin
    outdata = 8'h00;
    if (load && (address == SB_ADDR))
      outdata = sb;
    else if (load && (address == SC_ADDR))
      outdata = {start, 6'b111111, clksel};
  end

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sb        <= 8'h00;
      start     <= 1'b0;
      clksel    <= 1'b0;
      bitcnt    <= 4'd0;
      divcnt    <= 9'd0;
      sin_s1    <= 1'b1;
      sin_s2    <= 1'b1;
      sck_s1    <= 1'b1;
      sck_s2    <= 1'b1;
      sck_prev  <= 1'b1;
      sout      <= 1'b1;
      sclk_out  <= 1'b1;
      sclk_oe   <= 1'b0;
      irq       <= 1'b0;
      byte_done <= 1'b0;
      byte_data <= 8'h00;
    end else begin
      sin_s1    <= sin;
      sin_s2    <= sin_s1;
      sck_s1    <= sclk_in;
      sck_s2    <= sck_s1;
      sck_prev  <= sck_s2;
      irq       <= 1'b0;
      byte_done <= 1'b0;

      if (state == IDLE) begin
        if (wr_sb)
          sb <= indata;
        if (wr_sc) begin
          clksel <= indata[0];
          if (indata[7]) begin
            start  <= 1'b1;
            state  <= LOW;
            bitcnt <= 4'd0;
            divcnt <= 9'd0;
            if (indata[0]) begin
              sclk_oe  <= 1'b1;
              sclk_out <= 1'b0;
              sout     <= sb[7];
            end
          end
        end
      end else if (abort) begin
        state    <= IDLE;
        start    <= 1'b0;
        sclk_out <= 1'b1;
        sclk_oe  <= 1'b0;
        sout     <= 1'b1;
        bitcnt   <= 4'd0;
        divcnt   <= 9'd0;
      end else if (int_done || ext_done) begin
        state     <= IDLE;
        start     <= 1'b0;
        sclk_oe   <= 1'b0;
        sclk_out  <= 1'b1;
        sout      <= 1'b1;
        bitcnt    <= 4'd0;
        divcnt    <= 9'd0;
        irq       <= 1'b1;
        byte_done <= 1'b1;
        if (ext_done) begin
          sb        <= sb_shift;
          byte_data <= sb_shift;
        end else begin
          byte_data <= sb;
        end
      end else if (clksel) begin
        if (div_tc) begin
          divcnt <= 9'd0;
          if (state == LOW) begin
            sclk_out <= 1'b1;
            sb       <= sb_shift;
            bitcnt   <= bitcnt + 4'd1;
            state    <= HIGH;
          end else begin
            sclk_out <= 1'b0;
            sout     <= sb[7];
            state    <= LOW;
          end
        end else begin
          divcnt <= divcnt + 9'd1;
        end
      end else begin
        if (sck_rise) begin
          sb     <= sb_shift;
          bitcnt <= bitcnt + 4'd1;
        end else if (sck_fall) begin
          sout <= sb[7];
        end
      end
    end
  end

endmodule

// File: tb/tb_link_sio_ctrl.sv
// Self-checking bench for link_sio_ctrl: register table, directed internal/external
// transfers, abort, ignored writes, async reset, and randomized transfers.
module tb_link_sio_ctrl;
  localparam int HD = 4;
  localparam logic [15:0] SB = 16'hff01;
  localparam logic [15:0] SC = 16'hff02;

  logic        clockgb = 1'b0;
  logic        resetn  = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  indata  = 8'h00;
  logic        load    = 1'b0;
  logic        store   = 1'b0;
  logic        sin     = 1'b1;
  logic        sclk_in = 1'b1;
  logic [7:0]  outdata, byte_data;
  logic        sout, sclk_out, sclk_oe, irq, byte_done;

  int checks = 0;
  int errors = 0;

  link_sio_ctrl #(.SB_ADDR(SB), .SC_ADDR(SC), .HALF_DIV(HD)) dut (
    .clockgb(clockgb), .resetn(resetn), .address(address), .indata(indata),
    .outdata(outdata), .load(load), .store(store), .sin(sin), .sout(sout),
    .sclk_in(sclk_in), .sclk_out(sclk_out), .sclk_oe(sclk_oe), .irq(irq),
    .byte_done(byte_done), .byte_data(byte_data)
  );

  always #5 clockgb = ~clockgb;

  // sout is captured on every observed sclk_out falling edge
  logic       prev_sclk = 1'b1;
  logic [7:0] mon_bits  = 8'h00;
  int         mon_n = 0, irq_cnt = 0, done_cnt = 0;
  always @(negedge clockgb) begin
    if (prev_sclk && !sclk_out) begin
      mon_bits = {mon_bits[6:0], sout};
      mon_n    = mon_n + 1;
    end
    prev_sclk = sclk_out;
    if (irq) irq_cnt = irq_cnt + 1;
    if (byte_done) done_cnt = done_cnt + 1;
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clockgb);
    address = a; indata = d; store = 1'b1;
    @(negedge clockgb);
    store = 1'b0; address = 16'h0000; indata = 8'h00;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic ld, output logic [7:0] d);
    @(negedge clockgb);
    address = a; load = ld;
    #1 d = outdata;
    load = 1'b0; address = 16'h0000;
  endtask

  // Internal transfer; returns completion latency (cycles after the SC write edge) and sclk period.
  task automatic run_internal(input logic [7:0] sbv, input logic sinbit,
                              output int lat, output int period);
    int fall1, fall2;
    logic prev;
    sin = sinbit;
    cpu_write(SB, sbv);
    repeat (3) @(negedge clockgb);
    cpu_write(SC, 8'h81);
    lat = -1; fall1 = -1; fall2 = -1; prev = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      #1;
      if (prev && !sclk_out) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      prev = sclk_out;
      if (irq) begin lat = k; break; end
      @(negedge clockgb);
    end
    period = fall2 - fall1;
    @(negedge clockgb);
    #1 check8("irq_one_cycle", {7'b0, irq}, 8'h00);
  endtask

  // External transfer with npulses sclk_in pulses; lat = cycles from the last rising edge to irq.
  task automatic run_external(input logic [7:0] sbv, input logic [7:0] rx,
                              input int npulses, output int lat);
    cpu_write(SB, sbv);
    cpu_write(SC, 8'h80);
    #1 check8("ext_sclk_oe", {7'b0, sclk_oe}, 8'h00);
    lat = -1;
    for (int i = 0; i < npulses; i++) begin
      @(negedge clockgb);
      sin = rx[7-i]; sclk_in = 1'b0;
      repeat (6) @(negedge clockgb);
      #1 check8("ext_sout", {7'b0, sout}, {7'b0, sbv[7-i]});
      @(negedge clockgb);
      sclk_in = 1'b1;
      if (i == 7) begin
        for (int c = 1; c <= 10; c++) begin
          @(negedge clockgb);
          #1;
          if (irq) begin lat = c; break; end
        end
      end else begin
        repeat (6) @(negedge clockgb);
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        ld;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [7:0] rd, sbv, rx, exp_byte;
    logic sinbit;
    int lat, period, n0, i0, d0;

    vt[0]  = '{1'b0, 16'hff01, 8'h00, 1'b1, 8'h00};
    vt[1]  = '{1'b0, 16'hff02, 8'h00, 1'b1, 8'h7e};
    vt[2]  = '{1'b0, 16'hff00, 8'h00, 1'b1, 8'h00};
    vt[3]  = '{1'b0, 16'hff03, 8'h00, 1'b1, 8'h00};
    vt[4]  = '{1'b1, 16'hff01, 8'hc3, 1'b0, 8'h00};
    vt[5]  = '{1'b0, 16'hff01, 8'h00, 1'b1, 8'hc3};
    vt[6]  = '{1'b0, 16'hff01, 8'h00, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 16'hff02, 8'h01, 1'b0, 8'h00};
    vt[8]  = '{1'b0, 16'hff02, 8'h00, 1'b1, 8'h7f};
    vt[9]  = '{1'b1, 16'hff02, 8'h00, 1'b0, 8'h00};
    vt[10] = '{1'b0, 16'hff02, 8'h00, 1'b1, 8'h7e};

    repeat (3) @(negedge clockgb);
    #1;
    check8("rst_sout", {7'b0, sout}, 8'h01);
    check8("rst_sclk_out", {7'b0, sclk_out}, 8'h01);
    check8("rst_sclk_oe", {7'b0, sclk_oe}, 8'h00);
    check8("rst_irq", {7'b0, irq}, 8'h00);
    check8("rst_byte_done", {7'b0, byte_done}, 8'h00);
    check8("rst_byte_data", byte_data, 8'h00);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vt[i].wr) cpu_write(vt[i].addr, vt[i].data);
      else begin
        cpu_read(vt[i].addr, vt[i].ld, rd);
        check8($sformatf("table_%0d", i), rd, vt[i].exp);
      end
    end

    // Internal transfer, SB=A5, sin=1
    i0 = irq_cnt; d0 = done_cnt; n0 = mon_n;
    run_internal(8'ha5, 1'b1, lat, period);
    check_range("int_latency", lat, 16*HD-1, 16*HD+1);
    check_range("int_period", period, 2*HD, 2*HD);
    check_range("int_nbits", mon_n - n0, 8, 8);
    check8("int_sout_bits", mon_bits, 8'ha5);
    check_range("int_irq_cnt", irq_cnt - i0, 1, 1);
    check_range("int_done_cnt", done_cnt - d0, 1, 1);
    check8("int_byte_data", byte_data, 8'hff);
    cpu_read(SB, 1'b1, rd); check8("int_ff01", rd, 8'hff);
    cpu_read(SC, 1'b1, rd); check8("int_ff02", rd, 8'h7f);

    // External transfer, SB=3C, rx=5A
    i0 = irq_cnt;
    run_external(8'h3c, 8'h5a, 8, lat);
    check_range("ext_irq_latency", lat, 2, 3);
    check_range("ext_irq_cnt", irq_cnt - i0, 1, 1);
    check8("ext_byte_data", byte_data, 8'h5a);
    cpu_read(SB, 1'b1, rd); check8("ext_ff01", rd, 8'h5a);
    cpu_read(SC, 1'b1, rd); check8("ext_ff02", rd, 8'h7e);

    // Only 7 external pulses: still active, no irq; then abort
    i0 = irq_cnt;
    run_external(8'h81, 8'hff, 7, lat);
    repeat (20) @(negedge clockgb);
    check_range("ext7_no_irq", irq_cnt - i0, 0, 0);
    cpu_read(SC, 1'b1, rd); check8("ext7_ff02", rd, 8'hfe);
    cpu_write(SC, 8'h00);
    cpu_read(SC, 1'b1, rd); check8("ext7_abort_ff02", rd, 8'h7e);

    // Internal abort after 3 bits: 0x96 with three 1s shifted in
    sin = 1'b1;
    cpu_write(SB, 8'h96);
    repeat (3) @(negedge clockgb);
    i0 = irq_cnt;
    cpu_write(SC, 8'h81);
    repeat (23) @(negedge clockgb);
    cpu_write(SC, 8'h01);
    #1;
    check8("abort_sclk_oe", {7'b0, sclk_oe}, 8'h00);
    check8("abort_sclk_out", {7'b0, sclk_out}, 8'h01);
    cpu_read(SC, 1'b1, rd); check8("abort_ff02", rd, 8'h7f);
    cpu_read(SB, 1'b1, rd); check8("abort_ff01", rd, 8'hb7);
    repeat (100) @(negedge clockgb);
    check_range("abort_no_irq", irq_cnt - i0, 0, 0);
    cpu_write(SB, 8'h42);
    cpu_read(SB, 1'b1, rd); check8("abort_sb_write", rd, 8'h42);

    // Writes during an active transfer are ignored
    sin = 1'b1;
    cpu_write(SB, 8'h5a);
    repeat (3) @(negedge clockgb);
    i0 = irq_cnt; n0 = mon_n;
    cpu_write(SC, 8'h81);
    repeat (5) @(negedge clockgb);
    cpu_write(SB, 8'h00);
    cpu_write(SC, 8'h80);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clockgb);
      #1;
      if (irq) begin lat = k; break; end
    end
    check_range("ign_completed", lat, 0, 199);
    check_range("ign_nbits", mon_n - n0, 8, 8);
    check8("ign_sout_bits", mon_bits, 8'h5a);
    check8("ign_byte_data", byte_data, 8'hff);
    cpu_read(SC, 1'b1, rd); check8("ign_ff02", rd, 8'h7f);

    // Async reset mid-transfer
    cpu_write(SB, 8'h33);
    cpu_write(SC, 8'h81);
    repeat (20) @(negedge clockgb);
    #2 resetn = 1'b0;
    #1;
    check8("arst_sout", {7'b0, sout}, 8'h01);
    check8("arst_sclk_out", {7'b0, sclk_out}, 8'h01);
    check8("arst_sclk_oe", {7'b0, sclk_oe}, 8'h00);
    check8("arst_irq", {7'b0, irq}, 8'h00);
    check8("arst_byte_data", byte_data, 8'h00);
    cpu_read(SC, 1'b1, rd); check8("arst_ff02", rd, 8'h7e);
    cpu_read(SB, 1'b1, rd); check8("arst_ff01", rd, 8'h00);
    @(negedge clockgb);
    resetn = 1'b1;
    i0 = irq_cnt;
    repeat (100) @(negedge clockgb);
    check_range("arst_no_irq", irq_cnt - i0, 0, 0);

    // Randomized transfers against a byte-level model
    for (int it = 0; it < 8; it++) begin
      sbv = 8'($urandom);
      rx  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        sinbit   = 1'($urandom_range(0, 1));
        exp_byte = sinbit ? 8'hff : 8'h00;
        n0 = mon_n; i0 = irq_cnt;
        run_internal(sbv, sinbit, lat, period);
        check_range("rnd_int_latency", lat, 16*HD-1, 16*HD+1);
        check_range("rnd_int_nbits", mon_n - n0, 8, 8);
        check8("rnd_int_sout_bits", mon_bits, sbv);
        check_range("rnd_int_irq_cnt", irq_cnt - i0, 1, 1);
        check8("rnd_int_byte", byte_data, exp_byte);
      end else begin
        exp_byte = rx;
        run_external(sbv, rx, 8, lat);
        check_range("rnd_ext_latency", lat, 2, 3);
        check8("rnd_ext_byte", byte_data, exp_byte);
      end
      cpu_read(SB, 1'b1, rd); check8("rnd_ff01", rd, exp_byte);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
